// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin sharing of one combinational ALU between two requesters
// Ports: reqN_valid/ready/a/b/ctrl request channels, rspN_valid/ready/out/zero
// one-entry registered response slots, alu_a/b/ctrl to the ALU, alu_out/alu_is_zero back.
module alu_share_arbiter #(
  parameter int XLEN = 32,
  parameter int CTRL_W = 4,
  parameter bit PRIO_INIT = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [XLEN-1:0]   req0_a,
  input  logic [XLEN-1:0]   req0_b,
  input  logic [CTRL_W-1:0] req0_ctrl,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [XLEN-1:0]   req1_a,
  input  logic [XLEN-1:0]   req1_b,
  input  logic [CTRL_W-1:0] req1_ctrl,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic [XLEN-1:0]   rsp0_out,
  output logic              rsp0_zero,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [XLEN-1:0]   rsp1_out,
  output logic              rsp1_zero,
  output logic [XLEN-1:0]   alu_a,
  output logic [XLEN-1:0]   alu_b,
  output logic [CTRL_W-1:0] alu_ctrl,
  input  logic [XLEN-1:0]   alu_out,
  input  logic              alu_is_zero
);
  logic            elig0, elig1, gnt0, gnt1;
  logic            ptr_q, ptr_d;
  logic            rsp0_valid_q, rsp0_valid_d, rsp1_valid_q, rsp1_valid_d;
  logic [XLEN-1:0] rsp0_out_q, rsp0_out_d, rsp1_out_q, rsp1_out_d;
  logic            rsp0_zero_q, rsp0_zero_d, rsp1_zero_q, rsp1_zero_d;
  always_comb begin
    elig0 = req0_valid & (~rsp0_valid_q | rsp0_ready);
    elig1 = req1_valid & (~rsp1_valid_q | rsp1_ready);
    // ptr only breaks ties; rst masks grants so nothing is accepted during reset
    gnt0 = ~rst & elig0 & (~elig1 | ~ptr_q);
    gnt1 = ~rst & elig1 & (~elig0 | ptr_q);
    alu_a = gnt0 ? req0_a : gnt1 ? req1_a : '0;
    alu_b = gnt0 ? req0_b : gnt1 ? req1_b : '0;
    alu_ctrl = gnt0 ? req0_ctrl : gnt1 ? req1_ctrl : '0;
    ptr_d = gnt0 ? 1'b1 : gnt1 ? 1'b0 : ptr_q;
    rsp0_valid_d = gnt0 | (rsp0_valid_q & ~rsp0_ready);
    rsp1_valid_d = gnt1 | (rsp1_valid_q & ~rsp1_ready);
    rsp0_out_d = gnt0 ? alu_out : rsp0_out_q;
    rsp1_out_d = gnt1 ? alu_out : rsp1_out_q;
    rsp0_zero_d = gnt0 ? alu_is_zero : rsp0_zero_q;
    rsp1_zero_d = gnt1 ? alu_is_zero : rsp1_zero_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= PRIO_INIT;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp0_out_q <= '0;
      rsp1_out_q <= '0;
      rsp0_zero_q <= 1'b0;
      rsp1_zero_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp1_valid_q <= rsp1_valid_d;
      rsp0_out_q <= rsp0_out_d;
      rsp1_out_q <= rsp1_out_d;
      rsp0_zero_q <= rsp0_zero_d;
      rsp1_zero_q <= rsp1_zero_d;
    end
  end
  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign rsp0_valid = rsp0_valid_q;
  assign rsp1_valid = rsp1_valid_q;
  assign rsp0_out = rsp0_out_q;
  assign rsp1_out = rsp1_out_q;
  assign rsp0_zero = rsp0_zero_q;
  assign rsp1_zero = rsp1_zero_q;
endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: scoreboard bench for alu_share_arbiter with an adder ALU stub
module tb_alu_share_arbiter;
  logic        clk = 1'b0, rst = 1'b1;
  logic        req0_valid = 0, req1_valid = 0, req0_ready, req1_ready;
  logic [31:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
  logic [3:0]  req0_ctrl = 0, req1_ctrl = 0;
  logic        rsp0_valid, rsp1_valid, rsp0_ready = 0, rsp1_ready = 0;
  logic [31:0] rsp0_out, rsp1_out, alu_a, alu_b, alu_out;
  logic        rsp0_zero, rsp1_zero, alu_is_zero;
  logic [3:0]  alu_ctrl;
  int          n_chk = 0, n_fail = 0;
  logic [32:0] q0[$], q1[$];
  logic        ptr_m = 1'b0, fire0 = 0, fire1 = 0;
  logic        pv0 = 0, pv1 = 0, pr0 = 0, pr1 = 0;
  logic [67:0] pop0, pop1;
  alu_share_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_ctrl(req0_ctrl),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_ctrl(req1_ctrl),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_out(rsp0_out), .rsp0_zero(rsp0_zero),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_out(rsp1_out), .rsp1_zero(rsp1_zero),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_out(alu_out), .alu_is_zero(alu_is_zero)
  );
  assign alu_out = alu_a + alu_b;
  assign alu_is_zero = (alu_out == 32'd0);
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
    if (fire0) begin req0_a = $urandom; req0_b = $urandom; req0_ctrl = 4'($urandom_range(15)); end
    if (fire1) begin req1_a = $urandom; req1_b = $urandom; req1_ctrl = 4'($urandom_range(15)); end
  endtask
  always @(negedge clk) begin
    logic e0, e1, g0, g1;
    logic [31:0] s;
    if (rst) begin
      q0.delete();
      q1.delete();
      ptr_m = 1'b0;
      fire0 = 0;
      fire1 = 0;
      pv0 = 0;
      pv1 = 0;
      chk("rst_rdy0", req0_ready, 0);
      chk("rst_rdy1", req1_ready, 0);
    end else begin
      if (pv0 && !pr0) chk("stable0", {req0_a, req0_b, req0_ctrl}, pop0);
      if (pv1 && !pr1) chk("stable1", {req1_a, req1_b, req1_ctrl}, pop1);
      chk("v0", rsp0_valid, q0.size() != 0);
      chk("v1", rsp1_valid, q1.size() != 0);
      if (rsp0_valid && q0.size() != 0) chk("out0", {rsp0_out, rsp0_zero}, q0[0]);
      if (rsp1_valid && q1.size() != 0) chk("out1", {rsp1_out, rsp1_zero}, q1[0]);
      e0 = req0_valid && (q0.size() == 0 || rsp0_ready);
      e1 = req1_valid && (q1.size() == 0 || rsp1_ready);
      g0 = e0 && (!e1 || !ptr_m);
      g1 = e1 && (!e0 || ptr_m);
      chk("rdy0", req0_ready, g0);
      chk("rdy1", req1_ready, g1);
      if (rsp0_ready && q0.size() != 0) void'(q0.pop_front());
      if (rsp1_ready && q1.size() != 0) void'(q1.pop_front());
      if (g0) begin s = req0_a + req0_b; q0.push_back({s, s == 0}); ptr_m = 1'b1; end
      else if (g1) begin s = req1_a + req1_b; q1.push_back({s, s == 0}); ptr_m = 1'b0; end
      fire0 = g0;
      fire1 = g1;
      pv0 = req0_valid; pr0 = req0_ready; pop0 = {req0_a, req0_b, req0_ctrl};
      pv1 = req1_valid; pr1 = req1_ready; pop1 = {req1_a, req1_b, req1_ctrl};
    end
  end
  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 0;
    chk("rst_v0", rsp0_valid, 0);
    chk("rst_out0", rsp0_out, 0);
    req0_a = 4; req0_b = 8; req0_ctrl = 4'b1101; req0_valid = 1;
    #1;
    chk("t2_rdy", req0_ready, 1);
    chk("t2_ctrl", alu_ctrl, 4'b1101);
    step();
    chk("t2_v", rsp0_valid, 1);
    chk("t2_out", rsp0_out, 32'h0000000C);
    chk("t2_zero", rsp0_zero, 0);
    req0_a = 1; req0_b = 2; req0_ctrl = 3;
    req1_a = 5; req1_b = 6; req1_ctrl = 7; req1_valid = 1;
    #2 rst = 1;
    #1;
    chk("t1_v0", rsp0_valid, 0);
    chk("t1_rdy0", req0_ready, 0);
    chk("t1_out0", rsp0_out, 0);
    step();
    rst = 0;
    rsp0_ready = 1;
    rsp1_ready = 1;
    #1 chk("t1_ptr", req0_ready, 1);
    repeat (10) step();
    rsp1_ready = 0;
    repeat (6) step();
    rsp1_ready = 1;
    #1 chk("t4_rel", req1_ready, 1);
    step();
    req0_valid = 0;
    req1_valid = 0;
    step();
    req0_a = 32'hFFFFFFFF; req0_b = 1; req0_ctrl = 2; req0_valid = 1;
    step();
    req0_valid = 0;
    #1;
    chk("t5_out", rsp0_out, 0);
    chk("t5_zero", rsp0_zero, 1);
    chk("t5_idle", {alu_a, alu_b, alu_ctrl}, 0);
    step();
    req0_valid = 1;
    repeat (8) begin
      step();
      chk("t6_hold", rsp0_valid, 1);
    end
    req0_valid = 0;
    repeat (3) step();
    chk("end_q0", q0.size(), 0);
    chk("end_q1", q1.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
